// File: rtl/pkt_sf_fifo.sv
// Store-and-forward packet FIFO: a packet is offered downstream only once its
// last beat is buffered, with cut-through for packets longer than the buffer.
module pkt_sf_fifo #(
  parameter  int DATA_WD = 1,
  parameter  int DEPTH   = 16,
  localparam int ADDR_WD = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [DATA_WD-1:0] data_in,
  input  logic               last_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out,
  output logic               last_out,
  input  logic               ready_out,
  output logic [ADDR_WD:0]   count,
  output logic [ADDR_WD:0]   pkt_count,
  output logic               full,
  output logic               empty
);

  typedef logic [ADDR_WD:0] ptr_t;

  logic [DATA_WD:0] mem [DEPTH];
  logic [DATA_WD:0] head;
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  ptr_t             pkt_count_r;
  logic             ct_r;
  logic             push;
  logic             pop;

  // Pointers carry one extra bit so a full buffer is distinguishable from empty.
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WD{1'b0}}});
  assign ready_in  = !full;
  assign pkt_count = pkt_count_r;

  assign head      = mem[rd_ptr[ADDR_WD-1:0]];
  assign data_out  = head[DATA_WD-1:0];
  assign last_out  = head[DATA_WD];

  // A full buffer with no complete packet must start draining or it deadlocks.
  assign valid_out = !empty && ((pkt_count_r != '0) || ct_r || full);

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  // NOTE: the storage array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[ADDR_WD-1:0]] <= {last_in, data_in};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_r <= '0;
    end else if (flush) begin
      pkt_count_r <= '0;
    end else begin
      case ({push && last_in, pop && last_out})
        2'b10:   pkt_count_r <= pkt_count_r + ptr_t'(1);
        2'b01:   pkt_count_r <= pkt_count_r - ptr_t'(1);
        default: pkt_count_r <= pkt_count_r;
      endcase
    end
  end

  // Cut-through mode lasts until the oversize packet's final beat leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_r <= 1'b0;
    end else if (flush) begin
      ct_r <= 1'b0;
    end else if (pop && last_out) begin
      ct_r <= 1'b0;
    end else if (full && (pkt_count_r == '0)) begin
      ct_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_sf_fifo.sv
// Bench for pkt_sf_fifo: vector table, directed corner sequences, then random
// traffic checked against a queue-based packet model.
module tb_pkt_sf_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       valid_in;
  logic [0:0] data_in;
  logic       last_in;
  logic       ready_in;
  logic       valid_out;
  logic [0:0] data_out;
  logic       last_out;
  logic       ready_out;
  logic [4:0] count;
  logic [4:0] pkt_count;
  logic       full;
  logic       empty;

  int n_pass  = 0;
  int n_total = 0;

  pkt_sf_fifo #(.DATA_WD(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_in(valid_in), .data_in(data_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .last_out(last_out), .ready_out(ready_out),
    .count(count), .pkt_count(pkt_count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic vi; logic d; logic l; logic ro;
    logic exp_valid; logic exp_data; logic exp_last;
    int   exp_count; int exp_pkt;
  } vec_t;

  typedef struct { logic d; logic l; } beat_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vi, logic d, logic l, logic ro,
                              logic ev, logic ed, logic el, int ec, int ep);
    vec_t v;
    v.vi = vi; v.d = d; v.l = l; v.ro = ro;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el;
    v.exp_count = ec; v.exp_pkt = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_status(input string tag, input int cnt, input int pkt, input logic vld);
    check({tag, "_valid_out"}, 32'(valid_out), 32'(vld));
    check({tag, "_count"},     32'(count),     32'(cnt));
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'(pkt));
    check({tag, "_empty"},     32'(empty),     32'(cnt == 0));
    check({tag, "_full"},      32'(full),      32'(cnt == DEPTH));
    check({tag, "_ready_in"},  32'(ready_in),  32'(cnt != DEPTH));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
  task automatic drive(input logic vi, input logic d, input logic l, input logic ro, input logic fl);
    valid_in  = vi;
    data_in   = d;
    last_in   = l;
    ready_out = ro;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic od [20];
    int   in_idx;
    int   out_idx;
    beat_t q[$];
    logic  m_ct;

    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; last_in = 1'b0; ready_out = 1'b0; flush = 1'b0;
    #12;
    check_status("reset", 0, 0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_status("post_reset", 0, 0, 1'b0);

    // ---- vector table: store-and-forward, back-pressure, simultaneous last push/pop
    tbl.push_back(mk(1,1,0,1, 0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,1, 0,0,0, 1,0));
    tbl.push_back(mk(1,1,1,1, 0,0,0, 2,0));
    tbl.push_back(mk(0,0,0,1, 1,1,0, 3,1));
    tbl.push_back(mk(0,0,0,1, 1,0,0, 2,1));
    tbl.push_back(mk(0,0,0,1, 1,1,1, 1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,0, 0,0,0, 1,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0, 2,1));
    tbl.push_back(mk(1,0,1,0, 1,0,0, 3,1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0, 1,0,0, 4,2));
    tbl.push_back(mk(0,0,0,1, 1,0,0, 4,2));
    tbl.push_back(mk(0,0,0,1, 1,1,1, 3,2));
    tbl.push_back(mk(0,0,0,1, 1,1,0, 2,1));
    tbl.push_back(mk(0,0,0,1, 1,0,1, 1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,0, 0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,1, 1,1,1, 1,1));
    tbl.push_back(mk(0,0,0,0, 1,0,1, 1,1));
    tbl.push_back(mk(0,0,0,1, 1,0,1, 1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].vi, tbl[i].d, tbl[i].l, tbl[i].ro, 1'b0);
      check_status($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_pkt, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), 32'(data_out), 32'(tbl[i].exp_data));
        check($sformatf("vec%0d_last", i), 32'(last_out), 32'(tbl[i].exp_last));
      end
      tick();
    end

    // ---- full boundary
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, logic'(i & 1), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_status("full", 16, 16, 1'b1);
    check("full_head_data", 32'(data_out), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("full_push_pop", 15, 15, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("full_drain%0d_data", i), 32'(data_out), 32'(i & 1));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("full_drained", 0, 0, 1'b0);

    // ---- oversize packet: 20 beats, last only on beat 20
    for (int i = 0; i < 20; i++) od[i] = logic'($urandom_range(0, 1));
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, od[i], 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, od[16], 1'b0, 1'b0, 1'b0);
    check_status("oversize_full", 16, 0, 1'b1);
    tick();
    check("oversize_ct_set", 32'(dut.ct_r), 32'd1);
    in_idx = 16;
    out_idx = 0;
    for (int c = 0; c < 100 && out_idx < 20; c++) begin
      if (in_idx < 20) drive(1'b1, od[in_idx], in_idx == 19, 1'b1, 1'b0);
      else             drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (valid_out) begin
        check($sformatf("oversize_out%0d_data", out_idx), 32'(data_out), 32'(od[out_idx]));
        check($sformatf("oversize_out%0d_last", out_idx), 32'(last_out), 32'(out_idx == 19));
        out_idx++;
      end
      if (valid_in && ready_in) in_idx++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("oversize_beats_out", 32'(out_idx), 32'd20);
    check("oversize_ct_clear", 32'(dut.ct_r), 32'd0);
    check_status("oversize_done", 0, 0, 1'b0);

    // ---- flush with count=5 and a push offered in the same cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, logic'(i & 1), i == 1 || i == 4, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_status("pre_flush", 5, 2, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_status("post_flush", 0, 0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("after_flush_push", 1, 1, 1'b1);
    check("after_flush_data", 32'(data_out), 32'd0);
    check("after_flush_last", 32'(last_out), 32'd1);
    tick();

    // ---- async reset mid-packet
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("pre_rst", 3, 1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_status("async_rst", 0, 0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    check_status("after_rst", 0, 0, 1'b0);

    // ---- random traffic against a packet-level model
    q.delete();
    m_ct = 1'b0;
    for (int ph = 0; ph < 6; ph++) begin
      int ro_pct;
      int last_pct;
      ro_pct   = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 60 : 95;
      last_pct = (ph < 3) ? 30 : 5;
      for (int c = 0; c < 500; c++) begin
        logic vi, d, l, ro, fl;
        int   sz, nl;
        logic e_full, e_valid, do_push, do_pop;
        vi = logic'($urandom_range(0, 99) < 70);
        d  = logic'($urandom_range(0, 1));
        l  = logic'($urandom_range(0, 99) < last_pct);
        ro = logic'($urandom_range(0, 99) < ro_pct);
        fl = logic'($urandom_range(0, 199) == 0);
        drive(vi, d, l, ro, fl);

        sz = q.size();
        nl = 0;
        foreach (q[k]) if (q[k].l) nl++;
        e_full  = (sz == DEPTH);
        e_valid = (sz > 0) && (nl > 0 || m_ct || e_full);
        check_status("rand", sz, nl, e_valid);
        if (e_valid) begin
          check("rand_data", 32'(data_out), 32'(q[0].d));
          check("rand_last", 32'(last_out), 32'(q[0].l));
        end

        if (fl) begin
          q.delete();
          m_ct = 1'b0;
        end else begin
          do_push = vi && !e_full;
          do_pop  = e_valid && ro;
          if (do_pop && q[0].l)        m_ct = 1'b0;
          else if (e_full && nl == 0)  m_ct = 1'b1;
          if (do_pop) void'(q.pop_front());
          if (do_push) begin
            beat_t b;
            b.d = d;
            b.l = l;
            q.push_back(b);
          end
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
